// File: rtl/sprite_bank.sv
// sprite_bank: multi-sprite pixel store with a byte-stream load FSM and a registered read port.
// Define SPRITE_BANK_FLIP_EN to add the r_flip input for horizontally mirrored reads.
module sprite_bank #(
    parameter int SPRITE_NUM = 8,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int BPP        = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_start,
    input  logic [$clog2(SPRITE_NUM)-1:0] load_sprite,
    input  logic                          w_valid,
    input  logic [7:0]                    w_data,
    output logic                          w_ready,
    output logic                          load_busy,
    output logic                          load_done,
    output logic                          load_err,
    input  logic                          r_en,
    input  logic [$clog2(SPRITE_NUM)-1:0] r_sprite,
    input  logic [$clog2(SPRITE_W)-1:0]   r_x,
    input  logic [$clog2(SPRITE_H)-1:0]   r_y,
`ifdef SPRITE_BANK_FLIP_EN
    input  logic                          r_flip,
`endif
    output logic [BPP-1:0]                r_data,
    output logic                          r_valid
);
    localparam int PPB         = 8 / BPP;
    localparam int SPRITE_SIZE = SPRITE_W * SPRITE_H;
    localparam int SW          = $clog2(SPRITE_NUM);
    localparam int XW          = $clog2(SPRITE_W);
    localparam int YW          = $clog2(SPRITE_H);
    localparam int PW          = XW + YW;
    localparam int DEPTH       = SPRITE_NUM * SPRITE_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNPACK} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_sprite_sel;
    logic [PW:0]     r_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_sub;
    logic            r_w_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [BPP-1:0]  r_mem [DEPTH];

    logic            w_start_ok;
    logic            w_last;
    logic            w_we;
    logic [BPP-1:0]  w_wpix;
    logic [SW+PW-1:0] w_waddr;
    logic [XW-1:0]   w_col;
    logic [SW+PW-1:0] w_raddr;

    // A valid restart takes priority over any write in the same cycle.
    assign w_start_ok = load_start && ({1'b0, load_sprite} < (SW+1)'(SPRITE_NUM));
    assign w_last     = (r_cnt == (PW+1)'(SPRITE_SIZE - 1));
    assign w_we       = !w_start_ok &&
                        ((r_state == S_LOAD && w_valid && r_w_ready) || r_state == S_UNPACK);
    assign w_wpix     = (r_state == S_LOAD) ? w_data[7 -: BPP] : r_shift[7 -: BPP];
    assign w_waddr    = {r_sprite_sel, r_cnt[PW-1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sprite_sel <= '0;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_sub        <= '0;
            r_w_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so they are exactly one cycle wide.
            r_done <= 1'b0;
            r_err  <= load_start && !w_start_ok;
            if (w_start_ok) begin
                r_sprite_sel <= load_sprite;
                r_cnt        <= '0;
                r_sub        <= '0;
                r_state      <= S_LOAD;
                r_w_ready    <= 1'b1;
                r_busy       <= 1'b1;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_valid) begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_shift <= w_data << BPP;
                            r_sub   <= 3'd1;
                            if (PPB > 1) begin
                                r_state   <= S_UNPACK;
                                r_w_ready <= 1'b0;
                            end else if (w_last) begin
                                r_state   <= S_IDLE;
                                r_w_ready <= 1'b0;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    S_UNPACK: begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_shift <= r_shift << BPP;
                        r_sub   <= r_sub + 3'd1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_sub == 3'(PPB - 1)) begin
                            r_state   <= S_LOAD;
                            r_w_ready <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the pixel array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wpix;
    end

`ifdef SPRITE_BANK_FLIP_EN
    // Inverting the column bits equals SPRITE_W-1-x because SPRITE_W is a power of two.
    assign w_col = r_flip ? ~r_x : r_x;
`else
    assign w_col = r_x;
`endif
    assign w_raddr = {r_sprite, r_y, w_col};

    // Read and write share an edge, so a same-address read sees the old word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= r_en;
            if (r_en) r_data <= r_mem[w_raddr];
        end
    end

    assign w_ready   = r_w_ready;
    assign load_busy = r_busy;
    assign load_done = r_done;
    assign load_err  = r_err;
endmodule

// File: tb/tb_sprite_bank.sv
// tb_sprite_bank: directed, table-driven bench for sprite_bank (6 sprites, 32x32, 4 bpp).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sprite_bank;
    localparam int SN  = 6;
    localparam int SPW = 32;
    localparam int SPH = 32;
    localparam int BPP = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_start;
    logic [2:0] load_sprite;
    logic       w_valid;
    logic [7:0] w_data;
    logic       w_ready, load_busy, load_done, load_err;
    logic       r_en;
    logic [2:0] r_sprite;
    logic [4:0] r_x, r_y;
    logic [3:0] r_data;
    logic       r_valid;
`ifdef SPRITE_BANK_FLIP_EN
    logic       r_flip;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sprite_bank #(.SPRITE_NUM(SN), .SPRITE_W(SPW), .SPRITE_H(SPH), .BPP(BPP)) dut (
        .clock(clock), .reset(reset),
        .load_start(load_start), .load_sprite(load_sprite),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .r_en(r_en), .r_sprite(r_sprite), .r_x(r_x), .r_y(r_y),
`ifdef SPRITE_BANK_FLIP_EN
        .r_flip(r_flip),
`endif
        .r_data(r_data), .r_valid(r_valid)
    );

    typedef struct {
        logic [2:0] s;
        logic [4:0] x;
        logic [4:0] y;
        logic [3:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // mode 0: pixel p = (p+1) mod 16; mode 1: byte k = {k, ~k}; otherwise all 0xE.
    function automatic logic [7:0] stream_byte(input int mode, input int k);
        case (mode)
            0:       return {4'(2*k+1), 4'(2*k+2)};
            1:       return {4'(k), ~4'(k)};
            default: return 8'hEE;
        endcase
    endfunction

    task automatic start_load(input logic [2:0] idx);
        load_start  = 1'b1;
        load_sprite = idx;
        @(negedge clock);
        load_start  = 1'b0;
    endtask

    // Index i counts falling edges from the first one at which a byte may be offered.
    task automatic feed(input int nbytes, input int mode, input int stall_at, input bit chk_ready,
                        input bit wait_done, output int done_cnt, output int done_at);
        int acc = 0;
        int i = 0;
        int stalled = 0;
        int ready_err = 0;
        done_cnt = 0;
        done_at  = -1;
        while (i < 3000 && (acc < nbytes || (wait_done && done_cnt == 0))) begin
            if (load_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (chk_ready && done_cnt == 0 && w_ready !== 1'(i % 2 == 0)) ready_err++;
            if (acc == stall_at && stalled < 5 && w_ready === 1'b1) begin
                w_valid = 1'b0;
                stalled++;
            end else if (acc < nbytes && w_ready === 1'b1) begin
                w_valid = 1'b1;
                w_data  = stream_byte(mode, acc);
                acc++;
            end else begin
                w_valid = 1'b0;
            end
            @(negedge clock);
            i++;
        end
        w_valid = 1'b0;
        check("feed_in_budget", 32'(i < 3000), 1);
        if (chk_ready) check("w_ready_pattern_errs", ready_err, 0);
    endtask

    // Offers bytes after completion; nothing may be accepted and no further done pulse appears.
    task automatic post_done_quiet(input string name);
        int extra = 0;
        w_valid = 1'b1;
        w_data  = 8'h99;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            extra += int'(w_ready !== 1'b0) + int'(load_done !== 1'b0) + int'(load_busy !== 1'b0);
        end
        w_valid = 1'b0;
        check(name, extra, 0);
    endtask

    task automatic rd(input logic [2:0] s, input logic [4:0] x, input logic [4:0] y,
                      output logic [3:0] d, output logic v);
        r_en = 1'b1; r_sprite = s; r_x = x; r_y = y;
        @(negedge clock);
        d = r_data; v = r_valid;
        r_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         dc, da;
        logic [3:0] d;
        logic       v;

        vecs[0]  = '{3'd3, 5'd0,  5'd0,  4'd1};
        vecs[1]  = '{3'd3, 5'd1,  5'd0,  4'd2};
        vecs[2]  = '{3'd3, 5'd2,  5'd0,  4'd3};
        vecs[3]  = '{3'd3, 5'd3,  5'd0,  4'd4};
        vecs[4]  = '{3'd3, 5'd14, 5'd0,  4'd15};
        vecs[5]  = '{3'd3, 5'd5,  5'd1,  4'd6};
        vecs[6]  = '{3'd3, 5'd1,  5'd5,  4'd2};
        vecs[7]  = '{3'd3, 5'd30, 5'd31, 4'd15};
        vecs[8]  = '{3'd3, 5'd31, 5'd31, 4'd0};
        vecs[9]  = '{3'd0, 5'd0,  5'd0,  4'd0};
        vecs[10] = '{3'd0, 5'd1,  5'd0,  4'd15};
        vecs[11] = '{3'd0, 5'd14, 5'd12, 4'd7};
        vecs[12] = '{3'd0, 5'd15, 5'd12, 4'd8};
        vecs[13] = '{3'd0, 5'd16, 5'd12, 4'd8};
        vecs[14] = '{3'd0, 5'd17, 5'd12, 4'd7};
        vecs[15] = '{3'd0, 5'd30, 5'd31, 4'd15};
        vecs[16] = '{3'd0, 5'd31, 5'd31, 4'd0};

        reset = 1'b1; load_start = 1'b0; load_sprite = '0; w_valid = 1'b0; w_data = '0;
        r_en = 1'b0; r_sprite = '0; r_x = '0; r_y = '0;
`ifdef SPRITE_BANK_FLIP_EN
        r_flip = 1'b0;
`endif
        #22;
        check("rst w_ready", w_ready, 0);
        check("rst load_busy", load_busy, 0);
        check("rst load_done", load_done, 0);
        check("rst load_err", load_err, 0);
        check("rst r_valid", r_valid, 0);
        check("rst r_data", r_data, 0);
        @(negedge clock);
        reset = 1'b0;

        // Full load of sprite 3 with 0x12,0x34,... and an unstalled source.
        start_load(3'd3);
        check("s3 busy after start", load_busy, 1);
        check("s3 w_ready after start", w_ready, 1);
        feed(512, 0, -1, 1'b1, 1'b1, dc, da);
        check("s3 done count", dc, 1);
        check("s3 done latency", da, 1024);
        post_done_quiet("s3 post-done quiet");

        // Single read: one-cycle latency, data held once r_valid drops.
        r_en = 1'b1; r_sprite = 3'd3; r_x = 5'd1; r_y = 5'd0;
        check("read req cycle r_valid", r_valid, 0);
        @(negedge clock);
        r_en = 1'b0;
        check("read resp r_valid", r_valid, 1);
        check("read resp r_data", r_data, 2);
        @(negedge clock);
        check("read idle r_valid", r_valid, 0);
        check("read idle r_data held", r_data, 2);

        // Sprite 0 with a 5-cycle source stall after byte 200.
        start_load(3'd0);
        feed(512, 1, 200, 1'b0, 1'b1, dc, da);
        check("s0 done count", dc, 1);
        check("s0 done latency with stall", da, 1029);
        post_done_quiet("s0 post-done quiet");

        // Out-of-range sprite index.
        load_start = 1'b1; load_sprite = 3'd7;
        @(negedge clock);
        load_start = 1'b0;
        check("err pulse", load_err, 1);
        check("err busy", load_busy, 0);
        check("err w_ready", w_ready, 0);
        @(negedge clock);
        check("err pulse width", load_err, 0);
        check("err busy later", load_busy, 0);

        foreach (vecs[n]) begin
            rd(vecs[n].s, vecs[n].x, vecs[n].y, d, v);
            check($sformatf("rd s%0d x%0d y%0d", vecs[n].s, vecs[n].x, vecs[n].y), d, vecs[n].exp);
        end
        check("table last r_valid", v, 1);

`ifdef SPRITE_BANK_FLIP_EN
        r_flip = 1'b1;
        rd(3'd3, 5'd1, 5'd0, d, v);
        r_flip = 1'b0;
        check("flip x1 reads x30", d, 15);
        rd(3'd3, 5'd1, 5'd0, d, v);
        check("no flip x1", d, 2);
`endif

        // Reload sprite 3 with 0xEE: same-address read/write on the first byte, then reset mid-load.
        start_load(3'd3);
        w_valid = 1'b1; w_data = 8'hEE;
        r_en = 1'b1; r_sprite = 3'd3; r_x = 5'd0; r_y = 5'd0;
        @(negedge clock);
        w_valid = 1'b0; r_en = 1'b0;
        check("read-first old value", r_data, 1);
        feed(99, 2, -1, 1'b0, 1'b0, dc, da);
        check("partial load no done", dc, 0);
        #2 reset = 1'b1;
        #1;
        check("async rst w_ready", w_ready, 0);
        check("async rst load_busy", load_busy, 0);
        check("async rst r_valid", r_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        check("after rst load_done", load_done, 0);
        rd(3'd3, 5'd0, 5'd0, d, v);
        check("retained new pixel 0", d, 4'hE);
        rd(3'd3, 5'd6, 5'd6, d, v);
        check("retained new pixel 198", d, 4'hE);
        rd(3'd3, 5'd26, 5'd7, d, v);
        check("retained old pixel 250", d, 4'hB);
        check("after rst w_ready", w_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
